// File: rtl/crash_monitor_pkg.sv
// rtl/crash_monitor_pkg.sv - shared widths, game state encoding and crash colour
package crash_monitor_pkg;

    localparam int POS_W = 10;
    localparam int PIX_W = 12;
    localparam int CNT_W = 4;
    localparam int HOLD_W = 8;

    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_PLAYING = 2'b01;
    localparam logic [1:0] GS_CRASH   = 2'b10;
    localparam logic [1:0] GS_OVER    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = GS_IDLE,
        ST_PLAYING = GS_PLAYING,
        ST_CRASH   = GS_CRASH,
        ST_OVER    = GS_OVER
    } state_t;

    localparam logic [PIX_W-1:0] CRASH_COLOUR = 12'hF00;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = 4'd1;

    // Saturating increment used by the per-frame overlap counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
    endfunction

endpackage

// File: rtl/crash_monitor_if.sv
// rtl/crash_monitor_if.sv - pixel stream, button and game status bundle
interface crash_monitor_if import crash_monitor_pkg::*; ();

    logic [POS_W-1:0] pix_row;
    logic [POS_W-1:0] pix_col;
    logic [PIX_W-1:0] moving_cars_out;
    logic [PIX_W-1:0] player_car_out;
    logic             start_btn;
    logic [1:0]       game_state;
    logic [1:0]       lives;
    logic             freeze;
    logic             crash_pulse;
    logic [PIX_W-1:0] pixel_out;

    modport master (
        output pix_row, pix_col, moving_cars_out, player_car_out, start_btn,
        input  game_state, lives, freeze, crash_pulse, pixel_out
    );

    modport slave (
        input  pix_row, pix_col, moving_cars_out, player_car_out, start_btn,
        output game_state, lives, freeze, crash_pulse, pixel_out
    );

endinterface

// File: rtl/overlap_counter.sv
// rtl/overlap_counter.sv - per-frame saturating overlap count and end-of-frame tick
module overlap_counter
    import crash_monitor_pkg::*;
#(
    parameter int H_LAST = 639,
    parameter int V_LAST = 479
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] row,
    input  logic [POS_W-1:0] col,
    input  logic             overlap,
    output logic             frame_tick,
    output logic [CNT_W-1:0] eval_count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The frame's last pixel is included in the evaluated count, then the count restarts.
    always_comb begin
        frame_tick = (row == POS_W'(V_LAST)) && (col == POS_W'(H_LAST));
        eval_count = sat_inc(cnt_q, overlap);
        cnt_d      = frame_tick ? '0 : eval_count;
    end

    // Count register; reset drops any partial-frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crash_monitor.sv
// rtl/crash_monitor.sv - collision detection, lives/game FSM and pixel merge
module crash_monitor
    import crash_monitor_pkg::*;
#(
    parameter int H_LAST      = 639,
    parameter int V_LAST      = 479,
    parameter int LIVES_INIT  = 3,
    parameter int OVERLAP_MIN = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic           clk,
    input  logic           reset,
    crash_monitor_if.slave bus
);

    logic [POS_W-1:0]  row_q, row_d, col_q, col_d;
    logic [PIX_W-1:0]  moving_q, moving_d, player_q, player_d;
    logic              start_q, start_d;
    state_t            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pulse_q, pulse_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;

    logic              both_nz;
    logic              frame_tick;
    logic [CNT_W-1:0]  eval_count;
    logic              start_rise;
    logic              crash;

    // Input capture stage; everything downstream works on these copies.
    always_comb begin
        row_d    = bus.pix_row;
        col_d    = bus.pix_col;
        moving_d = bus.moving_cars_out;
        player_d = bus.player_car_out;
        start_d  = bus.start_btn;
    end

    // Input pipeline and start edge registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q    <= '0;
            col_q    <= '0;
            moving_q <= '0;
            player_q <= '0;
            start_q  <= 1'b0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            moving_q <= moving_d;
            player_q <= player_d;
            start_q  <= start_d;
        end
    end

    assign both_nz    = (moving_q != '0) && (player_q != '0);
    assign start_rise = bus.start_btn && !start_q;
    assign crash      = frame_tick && (state_q == ST_PLAYING) &&
                        (eval_count >= CNT_W'(OVERLAP_MIN));

    overlap_counter #(
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_overlap_counter (
        .clk        (clk),
        .reset      (reset),
        .row        (row_q),
        .col        (col_q),
        .overlap    (both_nz),
        .frame_tick (frame_tick),
        .eval_count (eval_count)
    );

    // Game FSM: start/restart, crash with life loss, timed hold before resuming.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_PLAYING;
                    lives_d = 2'(LIVES_INIT);
                    hold_d  = '0;
                end
            end
            ST_PLAYING: begin
                if (crash) begin
                    state_d = ST_CRASH;
                    lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                    hold_d  = '0;
                    pulse_d = 1'b1;
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                        state_d = (lives_q != 2'd0) ? ST_PLAYING : ST_OVER;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel merge: red flash where cars overlap during the crash hold.
    always_comb begin
        if (both_nz && (state_q == ST_CRASH)) begin
            pixel_d = CRASH_COLOUR;
        end else if (player_q != '0) begin
            pixel_d = player_q;
        end else begin
            pixel_d = moving_q;
        end
    end

    // Game state, lives, hold counter, crash strobe and merged pixel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lives_q <= 2'd0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            pixel_q <= pixel_d;
        end
    end

    assign bus.game_state  = state_q;
    assign bus.lives       = lives_q;
    assign bus.freeze      = (state_q != ST_PLAYING);
    assign bus.crash_pulse = pulse_q;
    assign bus.pixel_out   = pixel_q;

endmodule

// File: tb/tb_crash_monitor.sv
// tb/tb_crash_monitor.sv - scoreboard bench for crash_monitor on a tiny 8x4 frame
module tb_crash_monitor;

    localparam int HL = 7;
    localparam int VL = 3;
    localparam int FRAME = (HL + 1) * (VL + 1);
    localparam int HOLD = 60;

    typedef struct {
        int         due;
        logic [1:0] st;
        logic [1:0] lv;
        logic       pu;
        logic       fr;
    } st_exp_t;

    typedef struct {
        int          due;
        logic [11:0] px;
    } px_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulses = 0;

    st_exp_t sq[$];
    px_exp_t pq[$];

    logic [1:0]  m_state;
    int          m_lives, m_cnt, m_hold;
    logic        m_start_prev;
    logic [9:0]  m_row, m_col;
    logic [11:0] m_mc, m_pc;

    crash_monitor_if bus ();

    crash_monitor #(
        .H_LAST      (HL),
        .V_LAST      (VL),
        .LIVES_INIT  (3),
        .OVERLAP_MIN (4),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_state = 2'b00; m_lives = 0; m_cnt = 0; m_hold = 0;
        m_start_prev = 1'b0; m_row = '0; m_col = '0; m_mc = '0; m_pc = '0;
        sq.delete();
        pq.delete();
    endtask

    // One clock: check due scoreboard entries, drive a pixel, advance the reference model.
    task automatic step(input logic [9:0] r, input logic [9:0] c,
                        input logic [11:0] mc, input logic [11:0] pc, input logic sb);
        st_exp_t se;
        px_exp_t pe;
        logic    both, tick, rise, pu;
        int      inc;
        @(negedge clk);
        cyc++;
        if (bus.crash_pulse === 1'b1) pulses++;
        while (sq.size() > 0 && sq[0].due == cyc) begin
            se = sq.pop_front();
            total++;
            if (bus.game_state !== se.st || bus.lives !== se.lv ||
                bus.crash_pulse !== se.pu || bus.freeze !== se.fr) begin
                bad++;
                $display("FAIL sb_status cyc=%0d got st=%0d lv=%0d pu=%0b fr=%0b want st=%0d lv=%0d pu=%0b fr=%0b",
                         cyc, bus.game_state, bus.lives, bus.crash_pulse, bus.freeze,
                         se.st, se.lv, se.pu, se.fr);
            end
        end
        while (pq.size() > 0 && pq[0].due == cyc) begin
            pe = pq.pop_front();
            total++;
            if (bus.pixel_out !== pe.px) begin
                bad++;
                $display("FAIL sb_pixel cyc=%0d got=%h want=%h", cyc, bus.pixel_out, pe.px);
            end
        end
        bus.pix_row = r;
        bus.pix_col = c;
        bus.moving_cars_out = mc;
        bus.player_car_out = pc;
        bus.start_btn = sb;
        // model of the coming clock edge, which sees the previously driven pixel
        both = (m_mc != 0) && (m_pc != 0);
        inc = m_cnt + (both ? 1 : 0);
        if (inc > 15) inc = 15;
        tick = (m_row == 10'(VL)) && (m_col == 10'(HL));
        rise = sb && !m_start_prev;
        pu = 1'b0;
        case (m_state)
            2'b00, 2'b11: if (rise) begin m_state = 2'b01; m_lives = 3; m_hold = 0; end
            2'b01: if (tick && inc >= 4) begin
                m_state = 2'b10; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_hold = 0; pu = 1'b1;
            end
            default: if (tick) begin
                if (m_hold + 1 >= HOLD) begin
                    m_state = (m_lives > 0) ? 2'b01 : 2'b11; m_hold = 0;
                end else begin
                    m_hold++;
                end
            end
        endcase
        m_cnt = tick ? 0 : inc;
        m_start_prev = sb;
        se.due = cyc + 1; se.st = m_state; se.lv = 2'(m_lives); se.pu = pu; se.fr = (m_state != 2'b01);
        sq.push_back(se);
        pe.due = cyc + 2;
        if (mc != 0 && pc != 0 && m_state == 2'b10) pe.px = 12'hF00;
        else if (pc != 0) pe.px = pc;
        else pe.px = mc;
        pq.push_back(pe);
        m_row = r; m_col = c; m_mc = mc; m_pc = pc;
    endtask

    // Drive n_pix pixels of a frame; overlaps occupy [ov_first, ov_first+n_ov).
    task automatic run_frame(input int n_ov, input int ov_first, input int start_idx, input int n_pix);
        logic [11:0] mc, pc;
        for (int i = 0; i < n_pix; i++) begin
            mc = '0; pc = '0;
            if (i >= ov_first && i < ov_first + n_ov) begin
                mc = 12'h0A0 | 12'(i); pc = 12'h300 | 12'(i * 3 + 1);
            end else if (i % 5 == 1) begin
                mc = 12'h050 | 12'($urandom_range(1, 15));
            end else if (i % 7 == 2) begin
                pc = 12'h600 | 12'($urandom_range(1, 15));
            end
            step(10'(i / (HL + 1)), 10'(i % (HL + 1)), mc, pc, (i == start_idx));
        end
    endtask

    task automatic frame(input int n_ov, input int ov_first, input int start_idx);
        run_frame(n_ov, ov_first, start_idx, FRAME);
    endtask

    // Blank pixel at (0,0) so the last frame's evaluation edge completes, then look after the edge.
    task automatic settle_peek();
        step(10'd0, 10'd0, 12'h000, 12'h000, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        bus.pix_row = '0; bus.pix_col = '0; bus.moving_cars_out = '0;
        bus.player_car_out = '0; bus.start_btn = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.pixel_out !== 12'h000 || bus.game_state !== 2'b00 || bus.lives !== 2'd0 ||
                bus.freeze !== 1'b1 || bus.crash_pulse !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs k=%0d got px=%h st=%0d lv=%0d fr=%0b pu=%0b want px=000 st=0 lv=0 fr=1 pu=0",
                         k, bus.pixel_out, bus.game_state, bus.lives, bus.freeze, bus.crash_pulse);
            end
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
    endtask

    task automatic expect_status(input string name, input logic [1:0] st, input logic [1:0] lv, input logic fr);
        total++;
        if (bus.game_state !== st || bus.lives !== lv || bus.freeze !== fr) begin
            bad++;
            $display("FAIL %s got st=%0d lv=%0d fr=%0b want st=%0d lv=%0d fr=%0b",
                     name, bus.game_state, bus.lives, bus.freeze, st, lv, fr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        frame(6, 3, -1);
        settle_peek();
        expect_status("idle_overlaps_ignored", 2'b00, 2'd0, 1'b1);
    endtask

    task automatic test_start();
        frame(0, 0, 5);
        settle_peek();
        expect_status("start_to_playing", 2'b01, 2'd3, 1'b0);
    endtask

    task automatic test_no_crash();
        int p0;
        p0 = pulses;
        for (int f = 0; f < 10; f++) frame(3, (f % 2 == 0) ? FRAME - 3 : 0, -1);
        settle_peek();
        expect_status("three_per_frame_no_crash", 2'b01, 2'd3, 1'b0);
        total++;
        if (pulses !== p0) begin
            bad++;
            $display("FAIL no_crash_pulses got=%0d want=%0d", pulses - p0, 0);
        end
    endtask

    task automatic test_crash();
        int p0;
        p0 = pulses;
        frame(5, 9, -1);
        settle_peek();
        expect_status("crash_entered", 2'b10, 2'd2, 1'b1);
        frame(0, 0, -1);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL crash_pulse_count got=%0d want=%0d", pulses - p0, 1);
        end
    endtask

    task automatic test_hold();
        // one hold frame already elapsed inside test_crash
        for (int f = 1; f < HOLD - 1; f++) frame(6, 10, (f == 20) ? 12 : -1);
        settle_peek();
        expect_status("hold_not_done", 2'b10, 2'd2, 1'b1);
        frame(6, 10, -1);
        settle_peek();
        expect_status("hold_done_resume", 2'b01, 2'd2, 1'b0);
        frame(0, 0, 4);
        settle_peek();
        expect_status("start_ignored_playing", 2'b01, 2'd2, 1'b0);
    endtask

    task automatic test_edge_overlap();
        int p0;
        p0 = pulses;
        frame(4, FRAME - 4, -1);
        settle_peek();
        expect_status("last_pixel_overlap_crash", 2'b10, 2'd1, 1'b1);
        for (int f = 0; f < HOLD; f++) frame(0, 0, -1);
        frame(3, 0, -1);
        settle_peek();
        expect_status("next_frame_starts_zero", 2'b01, 2'd1, 1'b0);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL edge_pulse_count got=%0d want=%0d", pulses - p0, 1);
        end
    endtask

    task automatic test_game_over();
        frame(4, 0, -1);
        settle_peek();
        expect_status("last_life_crash", 2'b10, 2'd0, 1'b1);
        for (int f = 0; f < HOLD; f++) frame(2, 6, (f == 5) ? 7 : -1);
        settle_peek();
        expect_status("game_over", 2'b11, 2'd0, 1'b1);
        frame(8, 0, -1);
        settle_peek();
        expect_status("over_overlaps_ignored", 2'b11, 2'd0, 1'b1);
        frame(0, 0, 3);
        settle_peek();
        expect_status("restart_from_over", 2'b01, 2'd3, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        run_frame(10, 0, -1, 20);
        do_reset();
        frame(5, 2, -1);
        p0 = pulses;
        frame(3, 4, 0);
        settle_peek();
        expect_status("post_reset_start_wins", 2'b01, 2'd3, 1'b0);
        frame(2, 20, -1);
        settle_peek();
        expect_status("post_reset_no_crash", 2'b01, 2'd3, 1'b0);
        total++;
        if (pulses !== p0) begin
            bad++;
            $display("FAIL post_reset_pulses got=%0d want=%0d", pulses - p0, 0);
        end
    endtask

    initial begin
        bus.pix_row = '0; bus.pix_col = '0; bus.moving_cars_out = '0;
        bus.player_car_out = '0; bus.start_btn = 1'b0;
        model_clear();
        test_reset();
        test_start();
        test_no_crash();
        test_crash();
        test_hold();
        test_edge_overlap();
        test_game_over();
        test_reset_mid_frame();
        for (int k = 0; k < 3; k++) step(10'd0, 10'd0, 12'h000, 12'h000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crash_monitor.md
CRASH_MONITOR -- requirements
Module: crash_monitor

Interface
REQ-001 Parameter H_LAST, default 639, last active pixel column.
REQ-002 Parameter V_LAST, default 479, last active pixel row.
REQ-003 Parameter LIVES_INIT, default 3, lives loaded on game start (range 1..3).
REQ-004 Parameter OVERLAP_MIN, default 4, overlapping pixels per frame that constitute a crash (range 1..15).
REQ-005 Parameter HOLD_FRAMES, default 60, frames spent in CRASH before play resumes (range 1..255).
REQ-006 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pix_row, pix_col  in  10 each  current pixel location from the display timing generator.
REQ-009 moving_cars_out  in  12  obstacle pixel colour; nonzero = obstacle present.
REQ-010 player_car_out  in  12  player car pixel colour; nonzero = player present.
REQ-011 start_btn  in  1  debounced start button, level.
REQ-012 game_state  out  2  00 IDLE, 01 PLAYING, 10 CRASH, 11 OVER.
REQ-013 lives  out  2  remaining lives.
REQ-014 freeze  out  1  high = obstacle and player motion halted.
REQ-015 crash_pulse  out  1  one-cycle strobe on each detected crash.
REQ-016 pixel_out  out  12  merged pixel for the display.

Function
REQ-017 Inputs pix_row, pix_col, moving_cars_out and player_car_out SHALL be registered once; all detection uses the registered copies.
REQ-018 frame_tick SHALL assert for one cycle when the registered position equals (V_LAST, H_LAST).
REQ-019 A 4-bit overlap counter SHALL increment, saturating at 15, on each cycle where both registered colours are nonzero.
REQ-020 On frame_tick the counter SHALL be evaluated including the current cycle's overlap, then cleared to 0.
REQ-021 crash SHALL be detected on frame_tick when state is PLAYING and the evaluated count >= OVERLAP_MIN.
REQ-022 start_rise SHALL be a rising edge of start_btn, detected with one register.
REQ-023 IDLE -> PLAYING on start_rise, loading lives = LIVES_INIT and clearing the hold counter.
REQ-024 PLAYING -> CRASH on crash, with lives decremented and crash_pulse high for one cycle.
REQ-025 In CRASH, an 8-bit hold counter SHALL count frame_ticks; after HOLD_FRAMES ticks the next state SHALL be PLAYING if lives > 0, else OVER.
REQ-026 OVER -> PLAYING on start_rise, reloading lives = LIVES_INIT.
REQ-027 start_rise SHALL be ignored in PLAYING and CRASH.
REQ-028 Overlaps in IDLE, CRASH or OVER SHALL NOT produce crashes or decrement lives; the counter still runs and clears each frame.
REQ-029 freeze SHALL be high in IDLE, CRASH and OVER, and low only in PLAYING.
REQ-030 lives SHALL never decrement below 0.
REQ-031 pixel_out SHALL have one-cycle latency after the input registers.
REQ-032 pixel_out SHALL be 12'hF00 where both colours are nonzero and state is CRASH.
REQ-033 Otherwise pixel_out SHALL be player_car_out if that is nonzero, else moving_cars_out.
REQ-034 If start_rise and frame_tick coincide in IDLE, the start transition SHALL win and the frame SHALL NOT be evaluated for crash.

Reset
REQ-035 On reset: game_state IDLE, lives 0, freeze 1, crash_pulse 0, pixel_out 0, all counters and pipeline registers 0, including the start edge register.
REQ-036 Reset asserted mid-frame SHALL discard partial overlap counts; detection restarts at the next full frame.

Structure
REQ-037 A shared package SHALL hold the game_state encoding constants and the crash colour 12'hF00.
REQ-038 One sub-module, overlap_counter, SHALL contain the saturating counter plus frame_tick compare; the FSM, lives and pixel merge stay in the top.

Verification
REQ-039 Reset, then pulse start_btn -> game_state 01, lives 3, freeze 0.
REQ-040 In PLAYING, 5 overlapping pixels in one frame -> at frame end crash_pulse for 1 cycle, lives 2, state 10, freeze 1.
REQ-041 In PLAYING, 3 overlapping pixels per frame for 10 frames -> no crash, lives unchanged.
REQ-042 From CRASH with lives 2, run 60 frames -> state 01; with lives 0 -> state 11, and start_btn -> state 01, lives 3.
REQ-043 Overlap at pixel (479,639) as the 4th overlap of the frame -> crash is counted in that frame; next frame's counter starts at 0.
REQ-044 Assert reset mid-frame after 10 overlaps, release, start -> no crash in the first frame with fewer than 4 overlaps; pixel_out 0 during reset.
